// File: rtl/alu_seq_if.sv
// Handshake and operand bus between the control unit and the multi-cycle ALU.
// The master launches operations; the slave (the ALU) returns the result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [4:0]       opsel;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [3:0]       flags;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic [3:0]       flag_next;

  modport master (
    output start, opsel, srcA, srcB, flags,
    input  busy, done, res, flag_next
  );

  modport slave (
    input  start, opsel, srcA, srcB, flags,
    output busy, done, res, flag_next
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arith/logic and 1-bit shifts, iterative N-bit shifts,
// with a registered result/flags and a start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [2:0] K_LSA   = 3'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_res;
  logic [3:0]       r_flag;
  logic [WIDTH-1:0] r_acc;
  logic [CNTW-1:0]  r_cnt;
  logic [2:0]       r_kind;
  logic             r_cf;
  logic             r_of;
  logic             r_sc;

  logic [WIDTH-1:0] w_res;
  logic [WIDTH:0]   w_ext;
  logic [WIDTH:0]   w_cin;
  logic             w_cf;
  logic             w_of;
  logic             w_sc;
  logic             w_rsvd;
  logic [3:0]       w_flags;
  logic [CNTW-1:0]  w_cnt;
  logic             w_iter;
  logic             w_accept;
  logic [WIDTH-1:0] w_st_acc;
  logic             w_st_cf;
  logic             w_st_sc;

  // Returns {sign_changed, carry_out, shifted_value} for one bit-step.
  function automatic logic [WIDTH+1:0] shift_step(input logic [2:0] kind,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic cf);
    logic [WIDTH-1:0] r;
    logic             c;
    r = a;
    c = cf;
    case (kind)
      3'd0:    begin r = {1'b0, a[WIDTH-1:1]};      c = a[0];       end
      3'd1:    begin r = {a[WIDTH-2:0], 1'b0};      c = a[WIDTH-1]; end
      3'd2:    begin r = {a[WIDTH-1], a[WIDTH-1:1]}; c = a[0];       end
      3'd3:    begin r = {a[WIDTH-2:0], 1'b0};      c = a[WIDTH-1]; end
      3'd4:    begin r = {a[0], a[WIDTH-1:1]};      c = a[0];       end
      3'd5:    begin r = {a[WIDTH-2:0], a[WIDTH-1]}; c = a[WIDTH-1]; end
      3'd6:    begin r = {cf, a[WIDTH-1:1]};        c = a[0];       end
      default: begin r = {a[WIDTH-2:0], cf};        c = a[WIDTH-1]; end
    endcase
    return {r[WIDTH-1] ^ a[WIDTH-1], c, r};
  endfunction

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                            input logic cf, input logic of);
    return {(r == '0), r[WIDTH-1], cf, of};
  endfunction

  assign w_cnt    = bus.srcB[CNTW-1:0];
  assign w_iter   = (bus.opsel[4:3] == 2'b11) && (w_cnt != '0);
  assign w_accept = bus.start && (r_state != S_SHIFT);
  assign w_cin    = {{WIDTH{1'b0}}, bus.flags[1]};

  always_comb begin
    w_res  = '0;
    w_ext  = '0;
    w_cf   = bus.flags[1];
    w_of   = bus.flags[0];
    w_sc   = 1'b0;
    w_rsvd = 1'b0;
    if (bus.opsel[4]) begin
      if (!bus.opsel[3]) begin
        {w_sc, w_cf, w_res} = shift_step(bus.opsel[2:0], bus.srcA, bus.flags[1]);
        if (bus.opsel[2:0] == K_LSA) w_of = w_sc;
      end else begin
        // Zero-count iterative shift: value passes through, no step means no sign change
        w_res = bus.srcA;
        if (bus.opsel[2:0] == K_LSA) w_of = 1'b0;
      end
    end else begin
      case (bus.opsel[3:0])
        4'd0: w_res = bus.srcB;
        4'd1, 4'd10: begin
          w_ext = {1'b0, bus.srcA} + {1'b0, bus.srcB} + ((bus.opsel[3]) ? w_cin : '0);
          w_res = w_ext[WIDTH-1:0];
          w_cf  = w_ext[WIDTH];
          w_of  = (bus.srcA[WIDTH-1] == bus.srcB[WIDTH-1]) && (w_res[WIDTH-1] != bus.srcA[WIDTH-1]);
        end
        4'd2, 4'd11: begin
          w_ext = {1'b0, bus.srcA} - {1'b0, bus.srcB} - ((bus.opsel[3]) ? w_cin : '0);
          w_res = w_ext[WIDTH-1:0];
          w_cf  = w_ext[WIDTH];
          w_of  = (bus.srcA[WIDTH-1] != bus.srcB[WIDTH-1]) && (w_res[WIDTH-1] != bus.srcA[WIDTH-1]);
        end
        4'd3: begin
          w_ext = {1'b0, bus.srcA} + {{WIDTH{1'b0}}, 1'b1};
          w_res = w_ext[WIDTH-1:0];
          w_cf  = w_ext[WIDTH];
          w_of  = !bus.srcA[WIDTH-1] && w_res[WIDTH-1];
        end
        4'd4: begin
          w_ext = {1'b0, bus.srcA} - {{WIDTH{1'b0}}, 1'b1};
          w_res = w_ext[WIDTH-1:0];
          w_cf  = w_ext[WIDTH];
          w_of  = bus.srcA[WIDTH-1] && !w_res[WIDTH-1];
        end
        4'd5: w_res = bus.srcA & bus.srcB;
        4'd6: w_res = bus.srcA | bus.srcB;
        4'd7: w_res = bus.srcA ^ bus.srcB;
        4'd8: w_res = ~bus.srcA;
        4'd9: begin
          w_ext = '0 - {1'b0, bus.srcA};
          w_res = w_ext[WIDTH-1:0];
          w_cf  = w_ext[WIDTH];
          w_of  = (bus.srcA == {1'b1, {(WIDTH-1){1'b0}}});
        end
        default: w_rsvd = 1'b1;
      endcase
    end
    w_flags = w_rsvd ? bus.flags : pack_flags(w_res, w_cf, w_of);
  end

  assign {w_st_sc, w_st_cf, w_st_acc} = shift_step(r_kind, r_acc, r_cf);

  // Control and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_res   <= '0;
      r_flag  <= '0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          r_acc <= w_st_acc;
          r_cf  <= w_st_cf;
          r_sc  <= r_sc | w_st_sc;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNTW'(1)) begin
            r_res   <= w_st_acc;
            r_flag  <= pack_flags(w_st_acc, w_st_cf,
                                  (r_kind == K_LSA) ? (r_sc | w_st_sc) : r_of);
            r_state <= S_DONE;
          end
        end
        default: begin
          if (w_accept && w_iter) begin
            r_acc   <= bus.srcA;
            r_cnt   <= w_cnt;
            r_kind  <= bus.opsel[2:0];
            r_cf    <= bus.flags[1];
            r_of    <= bus.flags[0];
            r_sc    <= 1'b0;
            r_state <= S_SHIFT;
          end else if (w_accept) begin
            r_res   <= w_res;
            r_flag  <= w_flags;
            r_state <= S_DONE;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy      = (r_state == S_SHIFT);
  assign bus.done      = (r_state == S_DONE);
  assign bus.res       = r_res;
  assign bus.flag_next = r_flag;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors on a 16-bit instance plus a 32-bit spot check.
module tb_alu_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   last_busy;

  alu_seq_if #(.WIDTH(16)) bus16 ();
  alu_seq_if #(.WIDTH(32)) bus32 ();

  alu_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  alu_seq #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run16(input string tag, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] f, input logic [15:0] er,
                       input logic [3:0] ef, input int elat);
    int lat;
    int bcy;
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.opsel = op;
    bus16.srcA  = a;
    bus16.srcB  = b;
    bus16.flags = f;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    lat = 1;
    bcy = 0;
    while (!bus16.done && lat < 200) begin
      if (bus16.busy) bcy++;
      @(posedge clk);
      #1;
      lat++;
    end
    last_busy = bcy;
    check({tag, "_done"}, 32'(bus16.done), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_res"}, 32'(bus16.res), 32'(er));
    check({tag, "_flags"}, 32'(bus16.flag_next), 32'(ef));
  endtask

  initial begin
    int lat;
    n_checks = 0;
    n_errors = 0;
    last_busy = 0;
    rst = 1'b0;
    bus16.start = 1'b0; bus16.opsel = '0; bus16.srcA = '0; bus16.srcB = '0; bus16.flags = '0;
    bus32.start = 1'b0; bus32.opsel = '0; bus32.srcA = '0; bus32.srcB = '0; bus32.flags = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus16.busy), 32'd0);
    check("rst_done", 32'(bus16.done), 32'd0);
    check("rst_res", 32'(bus16.res), 32'd0);
    check("rst_flags", 32'(bus16.flag_next), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run16("add",   5'd1,  16'h7FFF, 16'h0001, 4'b0000, 16'h8000, 4'b0101, 1);
    run16("sub",   5'd2,  16'h0000, 16'h0001, 4'b0000, 16'hFFFF, 4'b0110, 1);
    run16("adc",   5'd10, 16'hFFFF, 16'h0000, 4'b0010, 16'h0000, 4'b1010, 1);
    run16("rsl",   5'd24, 16'h8001, 16'h0004, 4'b0000, 16'h0800, 4'b0000, 5);
    check("rsl_busy", 32'(last_busy), 32'd4);
    run16("lsa",   5'd27, 16'h4000, 16'h0002, 4'b0000, 16'h0000, 4'b1011, 3);
    run16("rscm",  5'd22, 16'h0001, 16'h0000, 4'b0010, 16'h8000, 4'b0110, 1);
    run16("cnt0",  5'd25, 16'h1234, 16'h0000, 4'b0011, 16'h1234, 4'b0011, 1);
    run16("rsvd",  5'd13, 16'h0005, 16'h0006, 4'b1010, 16'h0000, 4'b1010, 1);
    run16("neg",   5'd9,  16'h8000, 16'h0000, 4'b0000, 16'h8000, 4'b0111, 1);
    run16("and",   5'd5,  16'hF0F0, 16'h0FF0, 4'b0011, 16'h00F0, 4'b0011, 1);
    run16("inc",   5'd3,  16'hFFFF, 16'h0000, 4'b0000, 16'h0000, 4'b1010, 1);
    run16("dec",   5'd4,  16'h8000, 16'h0000, 4'b0000, 16'h7FFF, 4'b0001, 1);
    run16("sbb",   5'd11, 16'h0005, 16'h0003, 4'b0010, 16'h0001, 4'b0000, 1);
    run16("lsr",   5'd29, 16'h1234, 16'h0004, 4'b0000, 16'h2341, 4'b0010, 5);
    run16("rsam",  5'd18, 16'h8002, 16'h0000, 4'b0000, 16'hC001, 4'b0100, 1);

    // start held high while shifting, with different operands presented
    @(negedge clk);
    bus16.start = 1'b1; bus16.opsel = 5'd24; bus16.srcA = 16'h8001; bus16.srcB = 16'h0004;
    bus16.flags = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    bus16.opsel = 5'd1; bus16.srcA = 16'h0000; bus16.srcB = 16'h0000;
    repeat (2) @(negedge clk);
    bus16.start = 1'b0;
    lat = 3;
    #1;
    while (!bus16.done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("hold_lat", 32'(lat), 32'd5);
    check("hold_res", 32'(bus16.res), 32'h0800);

    // reset in the middle of a long shift
    @(negedge clk);
    bus16.start = 1'b1; bus16.opsel = 5'd24; bus16.srcA = 16'hFFFF; bus16.srcB = 16'h0008;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_busy", 32'(bus16.busy), 32'd0);
    check("mid_rst_done", 32'(bus16.done), 32'd0);
    check("mid_rst_res", 32'(bus16.res), 32'd0);
    check("mid_rst_flags", 32'(bus16.flag_next), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus16.done) lat++;
    end
    check("mid_rst_nodone", 32'(lat), 32'd0);

    // 32-bit spot check: rotate left by 31
    @(negedge clk);
    bus32.start = 1'b1; bus32.opsel = 5'd29; bus32.srcA = 32'h8000_0000; bus32.srcB = 32'd31;
    bus32.flags = 4'b0000;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    lat = 1;
    while (!bus32.done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("w32_lat", 32'(lat), 32'd32);
    check("w32_res", bus32.res, 32'h4000_0000);
    check("w32_flags", 32'(bus32.flag_next), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
